commit_trace_streamer: RTL and testbench
========================================

Name: commit_trace_streamer

Overview:
- Consumer end of the write-back trace interface. Each cycle the write-back stage presents a log-trace record; this block captures the accepted ones in a FIFO.
- Each record is serialized into a variable-length stream of 64-bit beats on a valid/ready port, which feeds the debug/host trace sink.
- Asserts a stall request to the core when the FIFO nears full.
- Counts records dropped on overflow.

Parameters:
- DATA_WIDTH, 64, register/memory data width.
- ADDR_WIDTH, 64, PC and memory address width.
- INSTR_WIDTH, 32, instruction width.
- REG_ADDR_W, 5, destination register index width.
- FIFO_DEPTH, 8, record FIFO entries; power of two, >= 4.

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  reset.
- i_log_trace  in  1  record valid; one per retired instruction.
- i_pc_log  in  ADDR_WIDTH  retired PC.
- i_instruction_log  in  INSTR_WIDTH  retired instruction.
- i_reg_we  in  1  instruction writes a GPR.
- i_rd_addr  in  REG_ADDR_W  destination register.
- i_rd_wdata  in  DATA_WIDTH  value written to rd.
- i_mem_we_log  in  1  instruction is a store.
- i_mem_addr_log  in  ADDR_WIDTH  store address.
- i_mem_write_data_log  in  DATA_WIDTH  store data.
- i_ecall_instr  in  1  instruction is ECALL.
- o_stall_req  out  1  FIFO almost full; core must hold write-back.
- o_tr_valid  out  1  beat valid.
- i_tr_ready  in  1  sink accepts beat.
- o_tr_data  out  64  beat payload.
- o_tr_last  out  1  final beat of record.
- o_drop_cnt  out  16  saturating count of dropped records.
- o_fifo_empty  out  1  FIFO holds no records.

Behaviour:
- Clock is i_clk. Reset is i_arst, asynchronous, active-high.
- Reset values: o_tr_valid=0, o_tr_data=0, o_tr_last=0, o_drop_cnt=0, o_stall_req=0, o_fifo_empty=1. FIFO pointers and count are 0, FSM is IDLE, sequence counter is 0.
- Push:
  - A record is pushed at a clock edge where i_log_trace=1 and the registered count < FIFO_DEPTH.
  - If i_log_trace=1 and count == FIFO_DEPTH, the record is dropped and o_drop_cnt increments, saturating at 0xFFFF. This holds even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- Sequence tag: 8-bit, stored with the record at push. Increments only on accepted pushes and wraps 0xFF to 0x00.
- o_stall_req = (count >= FIFO_DEPTH-1), registered from count. o_fifo_empty = (count == 0).
- Header beat layout:
  - [63:32] instruction
  - [31:27] rd_addr
  - [26] reg_we
  - [25] mem_we
  - [24] ecall
  - [23:16] sequence tag
  - [15:0] zero
- FSM states: IDLE, HDR, PC, RD, MADDR, MDATA.
  - IDLE: when FIFO is non-empty, pop the head into a holding register and go to HDR. o_tr_valid=0 in IDLE.
  - HDR then PC. After PC: go to RD if reg_we, else MADDR if mem_we, else end of record.
  - After RD: go to MADDR if mem_we, else end of record.
  - MADDR then MDATA, which ends the record.
  - A state advances only on o_tr_valid && i_tr_ready.
  - o_tr_last=1 on the final beat; a record of HDR+PC only ends on PC.
  - At end of record, return to IDLE. No back-to-back pop from the last beat; each record incurs one IDLE bubble.
- Beat payloads: PC is i_pc_log zero-extended to 64. RD is i_rd_wdata. MADDR and MDATA are the store address and data.
- Output stability: o_tr_data and o_tr_last are registered and hold stable while o_tr_valid=1 and i_tr_ready=0.
- Latency: a record pushed at edge N is loaded at edge N+1, and its HDR beat is valid in the cycle after edge N+1 (earliest).
- An incoming i_log_trace while the FIFO is empty but the FSM is busy is simply buffered.
- Reset mid-record: the in-flight record and FIFO contents are discarded. o_tr_valid drops immediately (async), and no partial beats are emitted after reset release.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- When defined:
  - A 64-bit free-running cycle counter runs, reset to 0 and incrementing every cycle.
  - Its value at the push edge is stored with each record.
  - A TS beat carrying that value is inserted between HDR and PC, and header bit [15] = 1.
- When undefined: no counter, no TS state, and header bit [15] = 0.

Test Plan:
- ALU record: instr=0x00500093, rd=1, reg_we=1, rd_wdata=5, pc=0x80000000, ready=1 -> beats 0x00500093_0C000000, 0x0000000080000000, 0x5 (last). No MADDR/MDATA beats.
- Store record: reg_we=0, mem_we=1, instr=0x00B12023, addr=0x1000, data=0xDEADBEEF -> HDR[25]=1 (0x00B12023_02000000 with seq), PC, 0x1000, 0xDEADBEEF (last).
- Backpressure: ready=0, push a record every cycle for 12 cycles, FIFO_DEPTH=8 -> 8 records held after the 1 popped into the holding register; o_stall_req=1 once count>=7; remaining pushes dropped and o_drop_cnt counts them; o_tr_data stable throughout. Release ready -> records emerge with sequence tags 0,1,2,... with no gaps.
- Sequence wrap: 257 accepted records -> tags ...0xFE, 0xFF, 0x00.
- Reset mid-record: assert i_arst during the PC beat with 3 records queued -> o_tr_valid=0 that cycle, o_fifo_empty=1, o_drop_cnt=0; after release, no beats until a new push.
- TRACE_TIMESTAMP_EN: first push at cycle 100 after reset release -> HDR[15]=1, second beat=100 (0x64), then PC.

Source files
------------

// File: rtl/commit_trace_streamer.sv
// -----------------------------------------------------------------------------
// commit_trace_streamer
//
// Purpose:
//   Receives the write-back trace interface and stores each accepted retire
//   record in a small FIFO. Each record is sent to the trace sink as a
//   variable-length burst of 64-bit beats on a valid/ready port:
//     HDR, [TS], PC, [RD], [MADDR, MDATA]
//   The block asks the core to stall when the FIFO is nearly full. It keeps a
//   saturating count of records that arrive while the FIFO is full.
//
// Optional build macro:
//   TRACE_TIMESTAMP_EN - adds a 64-bit free-running cycle counter. Its value at
//                        the push edge is sent as a TS beat between HDR and PC.
//                        It also sets header bit [15].
//
// Ports:
//   i_clk, i_arst           clock; asynchronous active-high reset
//   i_log_trace             record valid (one per retired instruction)
//   i_pc_log                retired PC
//   i_instruction_log       retired instruction
//   i_reg_we / i_rd_addr / i_rd_wdata          GPR write-back info
//   i_mem_we_log / i_mem_addr_log / i_mem_write_data_log   store info
//   i_ecall_instr           instruction is ECALL
//   o_stall_req             FIFO almost full (count >= FIFO_DEPTH-1)
//   o_tr_valid / i_tr_ready / o_tr_data / o_tr_last   beat stream to sink
//   o_drop_cnt              saturating count of dropped records
//   o_fifo_empty            FIFO holds no records
// -----------------------------------------------------------------------------
module commit_trace_streamer #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_log_trace,
  input  logic [ADDR_WIDTH-1:0]  i_pc_log,
  input  logic [INSTR_WIDTH-1:0] i_instruction_log,
  input  logic                   i_reg_we,
  input  logic [REG_ADDR_W-1:0]  i_rd_addr,
  input  logic [DATA_WIDTH-1:0]  i_rd_wdata,
  input  logic                   i_mem_we_log,
  input  logic [ADDR_WIDTH-1:0]  i_mem_addr_log,
  input  logic [DATA_WIDTH-1:0]  i_mem_write_data_log,
  input  logic                   i_ecall_instr,
  output logic                   o_stall_req,
  output logic                   o_tr_valid,
  input  logic                   i_tr_ready,
  output logic [63:0]            o_tr_data,
  output logic                   o_tr_last,
  output logic [15:0]            o_drop_cnt,
  output logic                   o_fifo_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   reg_we;
    logic [REG_ADDR_W-1:0]  rd;
    logic [DATA_WIDTH-1:0]  rd_wdata;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  maddr;
    logic [DATA_WIDTH-1:0]  mdata;
    logic                   ecall;
    logic [7:0]             seq;
`ifdef TRACE_TIMESTAMP_EN
    logic [63:0]            ts;
`endif
  } rec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PC,
    ST_RD,
    ST_MADDR,
`ifdef TRACE_TIMESTAMP_EN
    ST_MDATA,
    ST_TS
`else
    ST_MDATA
`endif
  } state_t;

  // Header beat: instr | rd | reg_we | mem_we | ecall | seq | ts flag | zero
  function automatic logic [63:0] f_header(input rec_t r);
    logic [63:0] h;
    h        = '0;
    h[63:32] = 32'(r.instr);
    h[31:27] = 5'(r.rd);
    h[26]    = r.reg_we;
    h[25]    = r.mem_we;
    h[24]    = r.ecall;
    h[23:16] = r.seq;
`ifdef TRACE_TIMESTAMP_EN
    h[15]    = 1'b1;
`endif
    return h;
  endfunction

  // The state after beat s of record r. ST_IDLE means s was the final beat.
  function automatic state_t f_next(input state_t s, input rec_t r);
    state_t n;
    case (s)
`ifdef TRACE_TIMESTAMP_EN
      ST_HDR:   n = ST_TS;
      ST_TS:    n = ST_PC;
`else
      ST_HDR:   n = ST_PC;
`endif
      ST_PC:    n = r.reg_we ? ST_RD : (r.mem_we ? ST_MADDR : ST_IDLE);
      ST_RD:    n = r.mem_we ? ST_MADDR : ST_IDLE;
      ST_MADDR: n = ST_MDATA;
      default:  n = ST_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [63:0] f_beat(input state_t s, input rec_t r);
    logic [63:0] b;
    case (s)
      ST_HDR:   b = f_header(r);
`ifdef TRACE_TIMESTAMP_EN
      ST_TS:    b = r.ts;
`endif
      ST_PC:    b = 64'(r.pc);
      ST_RD:    b = 64'(r.rd_wdata);
      ST_MADDR: b = 64'(r.maddr);
      ST_MDATA: b = 64'(r.mdata);
      default:  b = '0;
    endcase
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Record FIFO
  // ---------------------------------------------------------------------------
  rec_t              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [7:0]        r_seq;
  logic [15:0]       r_drop_cnt;
  logic              r_stall;
  logic              r_empty;

  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [CNT_W-1:0]  w_count_nxt;
  rec_t              w_rec_in;

`ifdef TRACE_TIMESTAMP_EN
  logic [63:0]       r_cycle;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
    end
  end
`endif

  always_comb begin
    w_rec_in          = '0;
    w_rec_in.pc       = i_pc_log;
    w_rec_in.instr    = i_instruction_log;
    w_rec_in.reg_we   = i_reg_we;
    w_rec_in.rd       = i_rd_addr;
    w_rec_in.rd_wdata = i_rd_wdata;
    w_rec_in.mem_we   = i_mem_we_log;
    w_rec_in.maddr    = i_mem_addr_log;
    w_rec_in.mdata    = i_mem_write_data_log;
    w_rec_in.ecall    = i_ecall_instr;
    w_rec_in.seq      = r_seq;
`ifdef TRACE_TIMESTAMP_EN
    w_rec_in.ts       = r_cycle;
`endif
  end

  // A full FIFO drops the new record, even if a pop happens in the same cycle.
  assign w_push = i_log_trace && (r_count != CNT_W'(FIFO_DEPTH));
  assign w_drop = i_log_trace && (r_count == CNT_W'(FIFO_DEPTH));

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec_in;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_stall    <= 1'b0;
      r_empty    <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_seq    <= r_seq + 8'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      r_count <= w_count_nxt;
      r_stall <= (w_count_nxt >= CNT_W'(FIFO_DEPTH - 1));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Beat serializer
  // ---------------------------------------------------------------------------
  state_t       r_state;
  state_t       w_state_nxt;
  state_t       w_adv;
  rec_t         r_hold;
  logic         r_tr_valid;
  logic [63:0]  r_tr_data;
  logic         r_tr_last;
  logic         w_vld_nxt;
  logic [63:0]  w_data_nxt;
  logic         w_last_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_vld_nxt   = r_tr_valid;
    w_data_nxt  = r_tr_data;
    w_last_nxt  = r_tr_last;
    w_pop       = 1'b0;
    w_adv       = f_next(r_state, r_hold);
    if (r_state == ST_IDLE) begin
      w_vld_nxt = 1'b0;
      if (r_count != '0) begin
        // The header is built straight from the FIFO head. This lets it appear
        // on the port in the same cycle the record moves to r_hold.
        w_pop       = 1'b1;
        w_state_nxt = ST_HDR;
        w_vld_nxt   = 1'b1;
        w_data_nxt  = f_header(r_mem[r_rd_ptr]);
        w_last_nxt  = 1'b0;
      end
    end else if (r_tr_valid && i_tr_ready) begin
      if (w_adv == ST_IDLE) begin
        // Return to IDLE for one cycle before the next pop.
        w_state_nxt = ST_IDLE;
        w_vld_nxt   = 1'b0;
        w_last_nxt  = 1'b0;
      end else begin
        w_state_nxt = w_adv;
        w_data_nxt  = f_beat(w_adv, r_hold);
        w_last_nxt  = (f_next(w_adv, r_hold) == ST_IDLE);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state    <= ST_IDLE;
      r_tr_valid <= 1'b0;
      r_tr_data  <= '0;
      r_tr_last  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tr_valid <= w_vld_nxt;
      r_tr_data  <= w_data_nxt;
      r_tr_last  <= w_last_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_pop) begin
      r_hold <= r_mem[r_rd_ptr];
    end
  end

  assign o_stall_req  = r_stall;
  assign o_fifo_empty = r_empty;
  assign o_drop_cnt   = r_drop_cnt;
  assign o_tr_valid   = r_tr_valid;
  assign o_tr_data    = r_tr_data;
  assign o_tr_last    = r_tr_last;

endmodule

// File: tb/tb_commit_trace_streamer.sv
module tb_commit_trace_streamer;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        log_trace = 1'b0;
  logic [63:0] pc_log = '0;
  logic [31:0] instr_log = '0;
  logic        reg_we = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [63:0] rd_wdata = '0;
  logic        mem_we = 1'b0;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_data = '0;
  logic        ecall = 1'b0;
  logic        stall_req;
  logic        tr_valid;
  logic        tr_ready = 1'b1;
  logic [63:0] tr_data;
  logic        tr_last;
  logic [15:0] drop_cnt;
  logic        fifo_empty;

  int total = 0;
  int bad   = 0;

  commit_trace_streamer dut (
    .i_clk                (clk),
    .i_arst               (arst),
    .i_log_trace          (log_trace),
    .i_pc_log             (pc_log),
    .i_instruction_log    (instr_log),
    .i_reg_we             (reg_we),
    .i_rd_addr            (rd_addr),
    .i_rd_wdata           (rd_wdata),
    .i_mem_we_log         (mem_we),
    .i_mem_addr_log       (mem_addr),
    .i_mem_write_data_log (mem_data),
    .i_ecall_instr        (ecall),
    .o_stall_req          (stall_req),
    .o_tr_valid           (tr_valid),
    .i_tr_ready           (tr_ready),
    .o_tr_data            (tr_data),
    .o_tr_last            (tr_last),
    .o_drop_cnt           (drop_cnt),
    .o_fifo_empty         (fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input logic [63:0] pc, input logic [31:0] ins,
                         input logic we, input logic [4:0] rd, input logic [63:0] wd,
                         input logic mwe, input logic [63:0] ma, input logic [63:0] md,
                         input logic ec);
    pc_log    = pc;
    instr_log = ins;
    reg_we    = we;
    rd_addr   = rd;
    rd_wdata  = wd;
    mem_we    = mwe;
    mem_addr  = ma;
    mem_data  = md;
    ecall     = ec;
  endtask

  initial begin
    logic [63:0] hdr;
    // ---------------- reset state ----------------
    step();
    step();
    chk("rst_valid", 64'(tr_valid), 64'd0);
    chk("rst_data",  tr_data, 64'd0);
    chk("rst_last",  64'(tr_last), 64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_empty", 64'(fifo_empty), 64'd1);
    arst = 1'b0;

`ifdef TRACE_TIMESTAMP_EN
    // ---------------- timestamp beat ----------------
    repeat (100) step();
    set_rec(64'h80000000, 32'h00000013, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
    log_trace = 1'b1;
    step();
    log_trace = 1'b0;
    step();
    chk("ts_hdr",   tr_data, 64'h00000013_00008000);
    chk("ts_valid", 64'(tr_valid), 64'd1);
    step();
    chk("ts_beat",  tr_data, 64'd100);
    chk("ts_last0", 64'(tr_last), 64'd0);
    step();
    chk("ts_pc",    tr_data, 64'h80000000);
    chk("ts_last",  64'(tr_last), 64'd1);
    step();
    chk("ts_idle",  64'(tr_valid), 64'd0);
`else
    // ---------------- ALU record ----------------
    set_rec(64'h80000000, 32'h00500093, 1'b1, 5'd1, 64'd5, 1'b0, 64'd0, 64'd0, 1'b0);
    log_trace = 1'b1;
    step();
    log_trace = 1'b0;
    chk("alu_vld_push", 64'(tr_valid), 64'd0);
    chk("alu_nonempty", 64'(fifo_empty), 64'd0);
    step();
    chk("alu_hdr_vld", 64'(tr_valid), 64'd1);
    chk("alu_hdr", tr_data, 64'h00500093_0C000000);
    chk("alu_hdr_last", 64'(tr_last), 64'd0);
    chk("alu_empty", 64'(fifo_empty), 64'd1);
    step();
    chk("alu_pc", tr_data, 64'h0000000080000000);
    chk("alu_pc_last", 64'(tr_last), 64'd0);
    step();
    chk("alu_rd", tr_data, 64'd5);
    chk("alu_rd_last", 64'(tr_last), 64'd1);
    step();
    chk("alu_done", 64'(tr_valid), 64'd0);

    // ---------------- store record ----------------
    set_rec(64'h80000004, 32'h00B12023, 1'b0, 5'd0, 64'd0, 1'b1, 64'h1000, 64'hDEADBEEF, 1'b0);
    log_trace = 1'b1;
    step();
    log_trace = 1'b0;
    step();
    chk("st_hdr", tr_data, 64'h00B12023_02010000);
    step();
    chk("st_pc", tr_data, 64'h80000004);
    step();
    chk("st_maddr", tr_data, 64'h1000);
    chk("st_maddr_last", 64'(tr_last), 64'd0);
    step();
    chk("st_mdata", tr_data, 64'hDEADBEEF);
    chk("st_mdata_last", 64'(tr_last), 64'd1);
    step();
    chk("st_done", 64'(tr_valid), 64'd0);

    // ---------------- HDR+PC record (ecall) ----------------
    set_rec(64'h80000008, 32'h00000073, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);
    log_trace = 1'b1;
    step();
    log_trace = 1'b0;
    step();
    chk("ec_hdr", tr_data, 64'h00000073_01020000);
    step();
    chk("ec_pc", tr_data, 64'h80000008);
    chk("ec_pc_last", 64'(tr_last), 64'd1);
    step();
    chk("ec_done", 64'(tr_valid), 64'd0);

    // ---------------- backpressure / overflow ----------------
    tr_ready = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      set_rec(64'h100 + 64'(k * 4), 32'h00100093, 1'b1, 5'(k), 64'(k), 1'b0, 64'd0, 64'd0, 1'b0);
      log_trace = 1'b1;
      step();
      chk("bp_stall", 64'(stall_req), (k >= 8) ? 64'd1 : 64'd0);
      chk("bp_drop", 64'(drop_cnt), (k >= 10) ? 64'(k - 9) : 64'd0);
      chk("bp_empty", 64'(fifo_empty), 64'd0);
      if (k >= 2) begin
        chk("bp_hold_data", tr_data, {32'h00100093, 5'd1, 3'b100, 8'd3, 16'h0});
        chk("bp_hold_vld", 64'(tr_valid), 64'd1);
      end
    end
    log_trace = 1'b0;
    tr_ready = 1'b1;
    for (int r = 0; r < 9; r++) begin
      hdr = {32'h00100093, 5'(r + 1), 3'b100, 8'(r + 3), 16'h0};
      chk("dr_hdr", tr_data, hdr);
      chk("dr_hdr_vld", 64'(tr_valid), 64'd1);
      step();
      chk("dr_pc", tr_data, 64'h100 + 64'((r + 1) * 4));
      step();
      chk("dr_rd", tr_data, 64'(r + 1));
      chk("dr_rd_last", 64'(tr_last), 64'd1);
      step();
      chk("dr_bubble", 64'(tr_valid), 64'd0);
      step();
    end
    chk("dr_empty", 64'(fifo_empty), 64'd1);
    chk("dr_drop", 64'(drop_cnt), 64'd3);
    chk("dr_stall", 64'(stall_req), 64'd0);

    // ---------------- sequence wrap (next tag is 12) ----------------
    set_rec(64'h2000, 32'h00000013, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
    for (int j = 0; j < 242; j++) begin
      log_trace = 1'b1;
      step();
      log_trace = 1'b0;
      step();
      step();
      step();
    end
    for (int j = 0; j < 3; j++) begin
      log_trace = 1'b1;
      step();
      log_trace = 1'b0;
      step();
      chk("wrap_hdr", tr_data, {32'h00000013, 8'h00, 8'(8'hFE + 8'(j)), 16'h0});
      step();
      chk("wrap_pc_last", 64'(tr_last), 64'd1);
      step();
    end

    // ---------------- reset mid-record ----------------
    tr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_rec(64'h3000 + 64'(k), 32'h00100093, 1'b1, 5'd2, 64'd7, 1'b0, 64'd0, 64'd0, 1'b0);
      log_trace = 1'b1;
      step();
    end
    log_trace = 1'b0;
    tr_ready = 1'b1;
    step();
    chk("mr_pc", tr_data, 64'h3000);
    arst = 1'b1;
    #1;
    chk("mr_valid", 64'(tr_valid), 64'd0);
    chk("mr_empty", 64'(fifo_empty), 64'd1);
    chk("mr_drop", 64'(drop_cnt), 64'd0);
    step();
    arst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("mr_quiet", 64'(tr_valid), 64'd0);
    end
    set_rec(64'h4000, 32'h00000013, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
    log_trace = 1'b1;
    step();
    log_trace = 1'b0;
    step();
    chk("mr_new_hdr", tr_data, 64'h00000013_00000000);
    step();
    chk("mr_new_pc", tr_data, 64'h4000);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
